// File: rtl/updn_counter_mod.sv
// updn_counter_mod: parametrised up/down counter with step, load, wrap/saturate and crossing pulses
// Ports: clk, reset (async, active-high); en, up_dwbar, step, sat_mode, load, load_val in;
//        count (registered), at_max/at_min (comb. bound flags), ovf/unf (registered one-cycle pulses) out.
module updn_counter_mod #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dwbar,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);
  localparam logic [WIDTH:0] MAX_X = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] MOD = MAX_X + {{WIDTH{1'b0}}, 1'b1};
  logic [WIDTH:0] sum, up_wrap, dn_wrap, dn_diff, nxt_raw;
  logic [WIDTH-1:0] nxt;
  logic up_over, dn_under, ovf_n, unf_n;
  // All arithmetic is one bit wider than the count so nothing truncates before the bound compare.
  always_comb begin
    sum = {1'b0, count} + {1'b0, step};
    up_wrap = sum - MOD;
    dn_wrap = {1'b0, count} + MOD - {1'b0, step};
    dn_diff = {1'b0, count} - {1'b0, step};
    up_over = sum > MAX_X;
    dn_under = step > count;
    nxt_raw = load ? {1'b0, load_val}
            : !en ? {1'b0, count}
            : up_dwbar ? (up_over ? (sat_mode ? MAX_X : up_wrap) : sum)
            : (dn_under ? (sat_mode ? '0 : dn_wrap) : dn_diff);
    // Single clamp covers out-of-range loads and keeps illegal steps inside 0..MAX_VAL.
    nxt = (nxt_raw > MAX_X) ? MAX_VAL : nxt_raw[WIDTH-1:0];
    ovf_n = !load && en && up_dwbar && up_over;
    unf_n = !load && en && !up_dwbar && dn_under;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RESET_VAL;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      count <= nxt;
      ovf <= ovf_n;
      unf <= unf_n;
    end
  end
  assign at_max = count == MAX_VAL;
  assign at_min = count == '0;
endmodule

// File: tb/tb_updn_counter_mod.sv
// tb_updn_counter_mod: directed self-checking bench for updn_counter_mod
module tb_updn_counter_mod;
  logic clk = 1'b0, reset = 1'b1;
  logic en = 1'b0, up_dwbar = 1'b1, sat_mode = 1'b0, load = 1'b0;
  logic [7:0] step = '0, load_val = '0;
  logic [7:0] count;
  logic at_max, at_min, ovf, unf;
  logic en2 = 1'b0, load2 = 1'b0;
  logic [7:0] step2 = '0, load_val2 = '0;
  logic [7:0] count2;
  logic at_max2, at_min2, ovf2, unf2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  updn_counter_mod #(.WIDTH(8), .MAX_VAL(8'd199), .RESET_VAL(8'd5)) u1 (
    .clk(clk), .reset(reset), .en(en), .up_dwbar(up_dwbar), .step(step),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .count(count),
    .at_max(at_max), .at_min(at_min), .ovf(ovf), .unf(unf));

  updn_counter_mod #(.WIDTH(8)) u2 (
    .clk(clk), .reset(reset), .en(en2), .up_dwbar(up_dwbar), .step(step2),
    .sat_mode(sat_mode), .load(load2), .load_val(load_val2), .count(count2),
    .at_max(at_max2), .at_min(at_min2), .ovf(ovf2), .unf(unf2));

  always @(posedge clk)
    if (!reset && en && !load) assert (step <= 8'd199) else $error("illegal step %0d", step);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect1(input string name, input logic [7:0] c, input logic o, input logic u);
    checks++;
    if (count !== c || ovf !== o || unf !== u) begin
      errors++;
      $display("FAIL %s: count=%0d ovf=%b unf=%b, required count=%0d ovf=%b unf=%b", name, count, ovf, unf, c, o, u);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    reset = 1'b0;
    do_load(8'd100);
    expect1("load_before_reset", 8'd100, 1'b0, 1'b0);
    #2 reset = 1'b1;
    load = 1'b1; load_val = 8'd77;
    #1;
    expect1("async_reset", 8'd5, 1'b0, 1'b0);
    checks++;
    if (at_max !== 1'b0 || at_min !== 1'b0) begin
      errors++; $display("FAIL reset_flags: at_max=%b at_min=%b, required 0 0", at_max, at_min);
    end
    tick();
    expect1("load_during_reset", 8'd5, 1'b0, 1'b0);
    #2 load = 1'b0; reset = 1'b0;
    en = 1'b1; up_dwbar = 1'b1; step = 8'd1;
    tick(); expect1("count_up_1", 8'd6, 1'b0, 1'b0);
    tick(); expect1("count_up_2", 8'd7, 1'b0, 1'b0);
    tick(); expect1("count_up_3", 8'd8, 1'b0, 1'b0);
  endtask

  task automatic test_up_wrap();
    do_load(8'd195);
    en = 1'b1; up_dwbar = 1'b1; step = 8'd10; sat_mode = 1'b0;
    tick(); expect1("up_wrap", 8'd5, 1'b1, 1'b0);
    step = 8'd1;
    tick(); expect1("up_after_wrap", 8'd6, 1'b0, 1'b0);
  endtask

  task automatic test_down_sat();
    do_load(8'd3);
    en = 1'b1; up_dwbar = 1'b0; step = 8'd7; sat_mode = 1'b1;
    tick(); expect1("down_sat", 8'd0, 1'b0, 1'b1);
    checks++;
    if (at_min !== 1'b1 || at_max !== 1'b0) begin
      errors++; $display("FAIL down_sat_flags: at_min=%b at_max=%b, required 1 0", at_min, at_max);
    end
    tick(); expect1("down_sat_hold_1", 8'd0, 1'b0, 1'b1);
    tick(); expect1("down_sat_hold_2", 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_down_wrap();
    do_load(8'd3);
    en = 1'b1; up_dwbar = 1'b0; step = 8'd7; sat_mode = 1'b0;
    tick(); expect1("down_wrap", 8'd196, 1'b0, 1'b1);
    do_load(8'd7);
    en = 1'b1; step = 8'd7;
    tick(); expect1("down_exact_zero", 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_exact_bound();
    do_load(8'd190);
    en = 1'b1; up_dwbar = 1'b1; step = 8'd9; sat_mode = 1'b0;
    tick(); expect1("exact_max", 8'd199, 1'b0, 1'b0);
    checks++;
    if (at_max !== 1'b1) begin
      errors++; $display("FAIL exact_max_flag: at_max=%b, required 1", at_max);
    end
    step = 8'd1;
    tick(); expect1("wrap_from_max", 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_up_sat();
    do_load(8'd198);
    en = 1'b1; up_dwbar = 1'b1; step = 8'd5; sat_mode = 1'b1;
    tick(); expect1("up_sat", 8'd199, 1'b1, 1'b0);
    tick(); expect1("up_sat_hold", 8'd199, 1'b1, 1'b0);
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 8'd250; en = 1'b1; up_dwbar = 1'b1; step = 8'd4;
    tick(); expect1("load_clamp", 8'd199, 1'b0, 1'b0);
    load_val = 8'd42;
    tick(); expect1("load_42", 8'd42, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0;
    tick(); expect1("hold", 8'd42, 1'b0, 1'b0);
    en = 1'b1; step = 8'd0;
    tick(); expect1("step_zero", 8'd42, 1'b0, 1'b0);
    en = 1'b0;
  endtask

  task automatic test_full_range();
    load2 = 1'b1; load_val2 = 8'd255;
    tick();
    load2 = 1'b0; en2 = 1'b1; up_dwbar = 1'b1; step2 = 8'd255; sat_mode = 1'b0;
    #1;
    checks++;
    if (u2.sum !== 9'd510) begin
      errors++; $display("FAIL full_sum9: sum=%0d, required 510", u2.sum);
    end
    tick();
    checks++;
    if (count2 !== 8'd254 || ovf2 !== 1'b1 || unf2 !== 1'b0) begin
      errors++; $display("FAIL full_wrap: count=%0d ovf=%b unf=%b, required 254 1 0", count2, ovf2, unf2);
    end
    en2 = 1'b0;
    tick();
    checks++;
    if (count2 !== 8'd254 || ovf2 !== 1'b0) begin
      errors++; $display("FAIL full_hold: count=%0d ovf=%b, required 254 0", count2, ovf2);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_down_wrap();
    test_exact_bound();
    test_up_sat();
    test_load_priority();
    test_full_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
